// File: rtl/lsu_dc_arb.sv
// Arbiter and issue register for the shared LSU_EX / D$ port: LQ replay, SQ retire and LSU_ID ops.
// Define LSU_ARB_STARVE_EN to compile in the anti-starvation counters and starved-priority override.

package procyon_lsu_pkg;
    typedef logic [31:0] procyon_addr_t;
    typedef logic [31:0] procyon_data_t;
    typedef logic [5:0]  procyon_tag_t;

    typedef enum logic [3:0] {
        LSU_FUNC_LB  = 4'd0,
        LSU_FUNC_LH  = 4'd1,
        LSU_FUNC_LW  = 4'd2,
        LSU_FUNC_LBU = 4'd3,
        LSU_FUNC_LHU = 4'd4,
        LSU_FUNC_SB  = 4'd5,
        LSU_FUNC_SH  = 4'd6,
        LSU_FUNC_SW  = 4'd7,
        LSU_FUNC_FENCE = 4'd8
    } procyon_lsu_func_t;
endpackage

module lsu_dc_arb
    import procyon_lsu_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_flush,

    input  logic              i_replay_en,
    input  procyon_lsu_func_t i_replay_lsu_func,
    input  procyon_addr_t     i_replay_addr,
    input  procyon_tag_t      i_replay_tag,
    output logic              o_replay_stall,

    input  logic              i_sq_retire_en,
    input  procyon_lsu_func_t i_sq_retire_lsu_func,
    input  procyon_addr_t     i_sq_retire_addr,
    input  procyon_data_t     i_sq_retire_data,
    input  procyon_tag_t      i_sq_retire_tag,
    output logic              o_sq_retire_stall,

    input  logic              i_id_en,
    input  procyon_lsu_func_t i_id_lsu_func,
    input  procyon_addr_t     i_id_addr,
    input  procyon_data_t     i_id_data,
    input  procyon_tag_t      i_id_tag,
    output logic              o_id_stall,

    input  logic              i_ex_stall,
    output logic              o_ex_valid,
    output logic [1:0]        o_ex_src,
    output procyon_lsu_func_t o_ex_lsu_func,
    output procyon_addr_t     o_ex_addr,
    output procyon_data_t     o_ex_data,
    output procyon_tag_t      o_ex_tag
);

    localparam int NUM_REQ = 3;

    localparam logic [1:0] SRC_REPLAY = 2'd0;
    localparam logic [1:0] SRC_SQ     = 2'd1;
    localparam logic [1:0] SRC_ID     = 2'd2;

    if (STARVE_LIMIT < 2 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("lsu_dc_arb: STARVE_LIMIT must be in 2..15");
    end

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] grant;

    assign req  = {i_id_en, i_sq_retire_en, i_replay_en};
    // Speculative requesters are masked on flush; retiring stores are already committed.
    assign elig = i_flush ? (req & 3'b010) : req;

`ifdef LSU_ARB_STARVE_EN
    logic [NUM_REQ-1:0] starved;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_starve
        logic [3:0] cnt_q;
        logic [3:0] cnt_d;

        assign starved[gi] = elig[gi] & (cnt_q >= 4'(STARVE_LIMIT));

        always_comb begin
            cnt_d = cnt_q;
            if (i_flush || grant[gi] || !req[gi]) begin
                cnt_d = 4'd0;
            end else if (!i_ex_stall && (cnt_q != 4'hf)) begin
                cnt_d = cnt_q + 4'd1;
            end
        end

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                cnt_q <= 4'd0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Any starved requester overrides the base order; lowest index still wins among them.
    assign pick = (|starved) ? starved : elig;
`else
    assign pick = elig;
`endif

    always_comb begin
        grant = '0;
        if (!i_ex_stall) begin
            if (pick[0]) begin
                grant = 3'b001;
            end else if (pick[1]) begin
                grant = 3'b010;
            end else if (pick[2]) begin
                grant = 3'b100;
            end
        end
    end

    assign o_replay_stall    = ~grant[0];
    assign o_sq_retire_stall = ~grant[1];
    assign o_id_stall        = ~grant[2];

    logic              ex_valid_q, ex_valid_d;
    logic [1:0]        ex_src_q, ex_src_d;
    procyon_lsu_func_t ex_lsu_func_q, ex_lsu_func_d;
    procyon_addr_t     ex_addr_q, ex_addr_d;
    procyon_data_t     ex_data_q, ex_data_d;
    procyon_tag_t      ex_tag_q, ex_tag_d;

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_src_d      = ex_src_q;
        ex_lsu_func_d = ex_lsu_func_q;
        ex_addr_d     = ex_addr_q;
        ex_data_d     = ex_data_q;
        ex_tag_d      = ex_tag_q;

        if (grant[0]) begin
            ex_valid_d    = 1'b1;
            ex_src_d      = SRC_REPLAY;
            ex_lsu_func_d = i_replay_lsu_func;
            ex_addr_d     = i_replay_addr;
            ex_data_d     = '0;
            ex_tag_d      = i_replay_tag;
        end else if (grant[1]) begin
            ex_valid_d    = 1'b1;
            ex_src_d      = SRC_SQ;
            ex_lsu_func_d = i_sq_retire_lsu_func;
            ex_addr_d     = i_sq_retire_addr;
            ex_data_d     = i_sq_retire_data;
            ex_tag_d      = i_sq_retire_tag;
        end else if (grant[2]) begin
            ex_valid_d    = 1'b1;
            ex_src_d      = SRC_ID;
            ex_lsu_func_d = i_id_lsu_func;
            ex_addr_d     = i_id_addr;
            ex_data_d     = i_id_data;
            ex_tag_d      = i_id_tag;
        end else if (!i_ex_stall) begin
            // LSU_EX consumed the held op this cycle, so it must not be issued twice.
            ex_valid_d = 1'b0;
        end else if (i_flush) begin
            ex_valid_d = ex_valid_q & (ex_src_q == SRC_SQ);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ex_valid_q    <= 1'b0;
            ex_src_q      <= SRC_REPLAY;
            ex_lsu_func_q <= LSU_FUNC_LB;
            ex_addr_q     <= '0;
            ex_data_q     <= '0;
            ex_tag_q      <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_src_q      <= ex_src_d;
            ex_lsu_func_q <= ex_lsu_func_d;
            ex_addr_q     <= ex_addr_d;
            ex_data_q     <= ex_data_d;
            ex_tag_q      <= ex_tag_d;
        end
    end

    assign o_ex_valid    = ex_valid_q;
    assign o_ex_src      = ex_src_q;
    assign o_ex_lsu_func = ex_lsu_func_q;
    assign o_ex_addr     = ex_addr_q;
    assign o_ex_data     = ex_data_q;
    assign o_ex_tag      = ex_tag_q;

endmodule
